ddr_rd_arbiter: RTL and testbench
=================================

Name: ddr_rd_arbiter

Overview:
- Shares the single DDR read master between two requesters: the feature line fetcher (DRAM feature read flag plus address) and the weight/bias loader.
- Splits each request into bursts of at most MAX_BURST beats and issues them one command at a time.
- Arbitrates round-robin at every burst boundary.
- Routes returned beats to the feature stream (I_feature/I_feature_dv of the conv core) or the weight stream (I_weight/I_weight_dv/I_weight_ch).

Parameters:
AXIWIDTH, 128, data beat width in bits
LITEWIDTH, 32, address width
LENWIDTH, 16, request length field width (beats)
MAX_BURST, 16, max beats per DDR command (power of 2, 1..256)

Ports:
I_clk  in  1  clock
I_rst  in  1  reset, synchronous, active-low
I_ap_start  in  1  layer start pulse; clears O_err
I_feat_req  in  1  feature fetch request pulse
I_feat_addr  in  LITEWIDTH  feature byte address
I_feat_beats  in  LENWIDTH  feature beats requested
I_wgt_req  in  1  weight/bias fetch request pulse
I_wgt_addr  in  LITEWIDTH  weight byte address
I_wgt_beats  in  LENWIDTH  weight beats requested
I_wgt_ch  in  1  1=weight, 0=bias; captured with I_wgt_req
O_feat_busy  out  1  feature request pending or in service
O_wgt_busy  out  1  weight request pending or in service
O_feat_done  out  1  one-cycle pulse, feature request complete
O_wgt_done  out  1  one-cycle pulse, weight request complete
O_cmd_valid  out  1  read command valid
O_cmd_addr  out  LITEWIDTH  burst byte address
O_cmd_len  out  8  burst beats minus 1
I_cmd_ready  in  1  master accepts command
I_rd_data  in  AXIWIDTH  read beat
I_rd_dv  in  1  read beat valid
I_rd_last  in  1  last beat of burst
O_feature  out  AXIWIDTH  routed feature beat
O_feature_dv  out  1  feature beat valid
O_weight  out  AXIWIDTH  routed weight/bias beat
O_weight_dv  out  1  weight beat valid
O_weight_ch  out  1  captured I_wgt_ch
O_err  out  2  sticky: bit0 request while busy, bit1 last/beat mismatch

Behaviour:
- Reset (I_rst=0 at a clock edge): state IDLE. All outputs 0. Pending flags, remaining counts and addresses 0. Last-grant pointer = weight, so feature wins the first tie.
- Per requester X (feat/wgt): on I_X_req with busy=0, capture addr, beats (REM) and ch (wgt only); set busy next cycle.
- I_X_req with busy=1: request ignored; O_err[0] set.
- beats=0: no command is issued; O_X_done pulses one cycle after the request; busy never sets.
- States:
  - IDLE: if both requesters pending, grant the one not granted last. If only one is pending, grant it. Go to CMD in the next cycle.
  - CMD: O_cmd_valid=1, O_cmd_addr=ADDR[X], O_cmd_len=min(REM[X],MAX_BURST)-1. Command fields are held stable while valid. On valid&ready go to DATA and load beat counter BC=0.
  - DATA: each I_rd_dv increments BC and forwards the beat. Burst ends when BC reaches O_cmd_len+1. Then REM[X] -= burst, ADDR[X] += burst*AXIWIDTH/8 (mod 2^LITEWIDTH, wraps silently). If REM[X]==0: O_X_done pulses, busy clears. Always return to IDLE (re-arbitrate every burst).
- Data routing: one-cycle registered latency. A beat accepted in cycle t appears on O_feature/O_feature_dv or O_weight/O_weight_dv in cycle t+1. The inactive stream's dv=0 and its data holds its previous value. O_weight_ch is held from capture until the next weight request.
- O_X_done asserts in the same cycle as the final routed beat.
- Mismatch handling: I_rd_last on a beat other than the counted final beat, no I_rd_last on the counted final beat, or I_rd_dv outside DATA: set O_err[1]. Count governs burst end; stray beats are dropped.
- Only one command is outstanding at a time; there is no command during DATA.
- Simultaneous request and done for the same requester in one cycle: done completes first, then the new request is captured (busy stays 1).
- I_ap_start clears O_err only; it does not abort service in progress.
- Reset mid-burst: immediate return to IDLE. In-flight beats are lost; the read master is reset by the same I_rst.

Test Plan:
- Feature req addr=0x1000, beats=40, MAX_BURST=16, always ready -> commands (0x1000,15), (0x1100,15), (0x1200,7). 40 O_feature_dv beats each 1 cycle after I_rd_dv. O_feat_done coincides with beat 40.
- Both req same cycle (feat 32 beats @0x0, wgt 32 beats @0x8000, ch=1) -> commands alternate F,W,F,W. O_weight_ch=1 throughout. Both done pulses fire; O_err=0.
- I_cmd_ready held 0 for 10 cycles -> O_cmd_valid, addr and len stable for all 10 cycles. No beats routed.
- wgt beats=0 -> O_wgt_done one cycle later, no O_cmd_valid, O_wgt_busy stays 0.
- Second I_feat_req while busy -> O_err=2'b01, original transfer unaffected. I_ap_start -> O_err=0.
- I_rd_last on beat 5 of a 16-beat burst -> O_err[1]=1, burst still ends after 16 beats. I_rst=0 mid-burst -> all outputs 0 next cycle.

Source files
------------

// File: rtl/ddr_rd_arbiter.sv
// Shares one DDR read master between the feature fetcher and the weight/bias loader.
// Requests are split into bursts of at most MAX_BURST beats and re-arbitrated round-robin per burst.
module ddr_rd_arbiter #(
    parameter int unsigned AXIWIDTH  = 128,
    parameter int unsigned LITEWIDTH = 32,
    parameter int unsigned LENWIDTH  = 16,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                 I_clk,
    input  logic                 I_rst,
    input  logic                 I_ap_start,
    input  logic                 I_feat_req,
    input  logic [LITEWIDTH-1:0] I_feat_addr,
    input  logic [LENWIDTH-1:0]  I_feat_beats,
    input  logic                 I_wgt_req,
    input  logic [LITEWIDTH-1:0] I_wgt_addr,
    input  logic [LENWIDTH-1:0]  I_wgt_beats,
    input  logic                 I_wgt_ch,
    output logic                 O_feat_busy,
    output logic                 O_wgt_busy,
    output logic                 O_feat_done,
    output logic                 O_wgt_done,
    output logic                 O_cmd_valid,
    output logic [LITEWIDTH-1:0] O_cmd_addr,
    output logic [7:0]           O_cmd_len,
    input  logic                 I_cmd_ready,
    input  logic [AXIWIDTH-1:0]  I_rd_data,
    input  logic                 I_rd_dv,
    input  logic                 I_rd_last,
    output logic [AXIWIDTH-1:0]  O_feature,
    output logic                 O_feature_dv,
    output logic [AXIWIDTH-1:0]  O_weight,
    output logic                 O_weight_dv,
    output logic                 O_weight_ch,
    output logic [1:0]           O_err
);

    localparam int unsigned BW    = 9;
    localparam int unsigned BYTES = AXIWIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t               state_q;
    logic                 feat_busy_q, wgt_busy_q;
    logic [LITEWIDTH-1:0] feat_addr_q, wgt_addr_q;
    logic [LENWIDTH-1:0]  feat_rem_q, wgt_rem_q;
    logic                 last_wgt_q, cur_wgt_q;
    logic [BW-1:0]        burst_q, bc_q;
    logic                 cmd_valid_q;
    logic [LITEWIDTH-1:0] cmd_addr_q;
    logic [7:0]           cmd_len_q;
    logic                 feat_done_q, wgt_done_q;
    logic [AXIWIDTH-1:0]  feature_q, weight_q;
    logic                 feature_dv_q, weight_dv_q, weight_ch_q;
    logic [1:0]           err_q;

    logic                 grant_wgt_c;
    logic [LENWIDTH-1:0]  sel_rem_c, cur_rem_c, rem_d;
    logic [LITEWIDTH-1:0] sel_addr_c, cur_addr_c, addr_d;
    logic [BW-1:0]        burst_d, bc_d;
    logic                 beat_fire_c, beat_final_c;
    logic                 feat_cmpl_c, wgt_cmpl_c, feat_acc_c, wgt_acc_c;
    logic [1:0]           err_d;

    // Grant selection, burst bookkeeping, request acceptance and error flags
    always_comb begin
        grant_wgt_c  = (feat_busy_q && wgt_busy_q) ? !last_wgt_q : wgt_busy_q;
        sel_rem_c    = grant_wgt_c ? wgt_rem_q : feat_rem_q;
        sel_addr_c   = grant_wgt_c ? wgt_addr_q : feat_addr_q;
        burst_d      = (sel_rem_c > LENWIDTH'(MAX_BURST)) ? BW'(MAX_BURST) : BW'(sel_rem_c);
        beat_fire_c  = (state_q == S_DATA) && I_rd_dv;
        bc_d         = bc_q + BW'(1);
        beat_final_c = beat_fire_c && (bc_d == burst_q);
        cur_rem_c    = cur_wgt_q ? wgt_rem_q : feat_rem_q;
        cur_addr_c   = cur_wgt_q ? wgt_addr_q : feat_addr_q;
        rem_d        = cur_rem_c - LENWIDTH'(burst_q);
        addr_d       = cur_addr_c + LITEWIDTH'(burst_q) * LITEWIDTH'(BYTES);
        feat_cmpl_c  = beat_final_c && !cur_wgt_q && (rem_d == '0);
        wgt_cmpl_c   = beat_final_c && cur_wgt_q && (rem_d == '0);
        // A request in the completing cycle is accepted as a fresh one
        feat_acc_c   = I_feat_req && (!feat_busy_q || feat_cmpl_c);
        wgt_acc_c    = I_wgt_req && (!wgt_busy_q || wgt_cmpl_c);
        err_d        = I_ap_start ? 2'b00 : err_q;
        if ((I_feat_req && !feat_acc_c) || (I_wgt_req && !wgt_acc_c)) begin
            err_d[0] = 1'b1;
        end
        if ((I_rd_dv && (state_q != S_DATA)) ||
            (beat_fire_c && (I_rd_last != beat_final_c))) begin
            err_d[1] = 1'b1;
        end
    end

    always_ff @(posedge I_clk) begin
        if (!I_rst) begin
            state_q      <= S_IDLE;
            feat_busy_q  <= 1'b0;
            wgt_busy_q   <= 1'b0;
            feat_addr_q  <= '0;
            wgt_addr_q   <= '0;
            feat_rem_q   <= '0;
            wgt_rem_q    <= '0;
            last_wgt_q   <= 1'b1;
            cur_wgt_q    <= 1'b0;
            burst_q      <= '0;
            bc_q         <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_len_q    <= '0;
            feat_done_q  <= 1'b0;
            wgt_done_q   <= 1'b0;
            feature_q    <= '0;
            weight_q     <= '0;
            feature_dv_q <= 1'b0;
            weight_dv_q  <= 1'b0;
            weight_ch_q  <= 1'b0;
            err_q        <= 2'b00;
        end else begin
            feat_done_q  <= 1'b0;
            wgt_done_q   <= 1'b0;
            feature_dv_q <= 1'b0;
            weight_dv_q  <= 1'b0;
            err_q        <= err_d;

            case (state_q)
                S_IDLE: begin
                    if (feat_busy_q || wgt_busy_q) begin
                        cur_wgt_q   <= grant_wgt_c;
                        last_wgt_q  <= grant_wgt_c;
                        burst_q     <= burst_d;
                        cmd_addr_q  <= sel_addr_c;
                        cmd_len_q   <= 8'(burst_d - BW'(1));
                        cmd_valid_q <= 1'b1;
                        state_q     <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (I_cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        bc_q        <= '0;
                        state_q     <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (I_rd_dv) begin
                        bc_q <= bc_d;
                        if (cur_wgt_q) begin
                            weight_q    <= I_rd_data;
                            weight_dv_q <= 1'b1;
                        end else begin
                            feature_q    <= I_rd_data;
                            feature_dv_q <= 1'b1;
                        end
                        if (beat_final_c) begin
                            state_q <= S_IDLE;
                            if (cur_wgt_q) begin
                                wgt_rem_q  <= rem_d;
                                wgt_addr_q <= addr_d;
                            end else begin
                                feat_rem_q  <= rem_d;
                                feat_addr_q <= addr_d;
                            end
                            if (feat_cmpl_c) begin
                                feat_done_q <= 1'b1;
                                feat_busy_q <= 1'b0;
                            end
                            if (wgt_cmpl_c) begin
                                wgt_done_q <= 1'b1;
                                wgt_busy_q <= 1'b0;
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // Capture placed after completion so a back-to-back request wins
            if (feat_acc_c) begin
                if (I_feat_beats == '0) begin
                    feat_done_q <= 1'b1;
                end else begin
                    feat_busy_q <= 1'b1;
                    feat_addr_q <= I_feat_addr;
                    feat_rem_q  <= I_feat_beats;
                end
            end
            if (wgt_acc_c) begin
                weight_ch_q <= I_wgt_ch;
                if (I_wgt_beats == '0) begin
                    wgt_done_q <= 1'b1;
                end else begin
                    wgt_busy_q <= 1'b1;
                    wgt_addr_q <= I_wgt_addr;
                    wgt_rem_q  <= I_wgt_beats;
                end
            end
        end
    end

    assign O_feat_busy  = feat_busy_q;
    assign O_wgt_busy   = wgt_busy_q;
    assign O_feat_done  = feat_done_q;
    assign O_wgt_done   = wgt_done_q;
    assign O_cmd_valid  = cmd_valid_q;
    assign O_cmd_addr   = cmd_addr_q;
    assign O_cmd_len    = cmd_len_q;
    assign O_feature    = feature_q;
    assign O_feature_dv = feature_dv_q;
    assign O_weight     = weight_q;
    assign O_weight_dv  = weight_dv_q;
    assign O_weight_ch  = weight_ch_q;
    assign O_err        = err_q;

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Directed bench for ddr_rd_arbiter: burst splitting, round-robin, stalls, errors, reset.
module tb_ddr_rd_arbiter;

    logic         I_clk = 1'b0;
    logic         I_rst = 1'b0;
    logic         I_ap_start = 1'b0;
    logic         I_feat_req = 1'b0;
    logic [31:0]  I_feat_addr = '0;
    logic [15:0]  I_feat_beats = '0;
    logic         I_wgt_req = 1'b0;
    logic [31:0]  I_wgt_addr = '0;
    logic [15:0]  I_wgt_beats = '0;
    logic         I_wgt_ch = 1'b0;
    logic         O_feat_busy, O_wgt_busy, O_feat_done, O_wgt_done;
    logic         O_cmd_valid;
    logic [31:0]  O_cmd_addr;
    logic [7:0]   O_cmd_len;
    logic         I_cmd_ready = 1'b0;
    logic [127:0] I_rd_data = '0;
    logic         I_rd_dv = 1'b0;
    logic         I_rd_last = 1'b0;
    logic [127:0] O_feature, O_weight;
    logic         O_feature_dv, O_weight_dv, O_weight_ch;
    logic [1:0]   O_err;

    int n_cmp = 0;
    int n_err = 0;

    ddr_rd_arbiter dut (
        .I_clk(I_clk), .I_rst(I_rst), .I_ap_start(I_ap_start),
        .I_feat_req(I_feat_req), .I_feat_addr(I_feat_addr), .I_feat_beats(I_feat_beats),
        .I_wgt_req(I_wgt_req), .I_wgt_addr(I_wgt_addr), .I_wgt_beats(I_wgt_beats),
        .I_wgt_ch(I_wgt_ch),
        .O_feat_busy(O_feat_busy), .O_wgt_busy(O_wgt_busy),
        .O_feat_done(O_feat_done), .O_wgt_done(O_wgt_done),
        .O_cmd_valid(O_cmd_valid), .O_cmd_addr(O_cmd_addr), .O_cmd_len(O_cmd_len),
        .I_cmd_ready(I_cmd_ready),
        .I_rd_data(I_rd_data), .I_rd_dv(I_rd_dv), .I_rd_last(I_rd_last),
        .O_feature(O_feature), .O_feature_dv(O_feature_dv),
        .O_weight(O_weight), .O_weight_dv(O_weight_dv), .O_weight_ch(O_weight_ch),
        .O_err(O_err)
    );

    always #5 I_clk = ~I_clk;

    task automatic tick();
        @(posedge I_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        I_rst = 1'b0;
        tick();
        tick();
        I_rst = 1'b1;
    endtask

    task automatic wait_cmd();
        int k = 0;
        while (!O_cmd_valid && k < 20) begin
            tick();
            k++;
        end
        chk("cmd_valid", 128'(O_cmd_valid), 128'(1));
    endtask

    task automatic expect_cmd(input logic [31:0] addr, input logic [7:0] len);
        wait_cmd();
        chk("cmd_addr", 128'(O_cmd_addr), 128'(addr));
        chk("cmd_len", 128'(O_cmd_len), 128'(len));
        I_cmd_ready = 1'b1;
        tick();
        I_cmd_ready = 1'b0;
    endtask

    task automatic burst(input int n, input bit wgt, input int last_at,
                         input bit done_exp, input logic [31:0] base);
        logic [127:0] d;
        for (int i = 0; i < n; i++) begin
            d = {96'h0, base + 32'(i)};
            I_rd_data = d;
            I_rd_dv   = 1'b1;
            I_rd_last = (i == last_at);
            tick();
            if (wgt) begin
                chk("wgt_dv", 128'(O_weight_dv), 128'(1));
                chk("wgt_data", O_weight, d);
                chk("feat_dv_off", 128'(O_feature_dv), 128'(0));
                chk("wgt_done", 128'(O_wgt_done), 128'(done_exp && (i == n - 1)));
                chk("wgt_ch", 128'(O_weight_ch), 128'(1));
            end else begin
                chk("feat_dv", 128'(O_feature_dv), 128'(1));
                chk("feat_data", O_feature, d);
                chk("wgt_dv_off", 128'(O_weight_dv), 128'(0));
                chk("feat_done", 128'(O_feat_done), 128'(done_exp && (i == n - 1)));
            end
        end
        I_rd_dv   = 1'b0;
        I_rd_last = 1'b0;
        if (done_exp) begin
            if (wgt) chk("wgt_busy_clr", 128'(O_wgt_busy), 128'(0));
            else     chk("feat_busy_clr", 128'(O_feat_busy), 128'(0));
        end
    endtask

    task automatic feat_req(input logic [31:0] addr, input logic [15:0] beats);
        I_feat_req = 1'b1;
        I_feat_addr = addr;
        I_feat_beats = beats;
        tick();
        I_feat_req = 1'b0;
    endtask

    task automatic ap_clear();
        I_ap_start = 1'b1;
        tick();
        I_ap_start = 1'b0;
        chk("err_clear", 128'(O_err), 128'(0));
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_cmd_valid", 128'(O_cmd_valid), 128'(0));
        chk("rst_feat_busy", 128'(O_feat_busy), 128'(0));
        chk("rst_wgt_busy", 128'(O_wgt_busy), 128'(0));
        chk("rst_err", 128'(O_err), 128'(0));
        chk("rst_feature", O_feature, 128'(0));
        chk("rst_weight_ch", 128'(O_weight_ch), 128'(0));

        // 40-beat feature request split 16/16/8
        feat_req(32'h1000, 16'd40);
        chk("feat_busy_set", 128'(O_feat_busy), 128'(1));
        expect_cmd(32'h1000, 8'd15);
        burst(16, 1'b0, 15, 1'b0, 32'hF000);
        expect_cmd(32'h1100, 8'd15);
        burst(16, 1'b0, 15, 1'b0, 32'hF010);
        expect_cmd(32'h1200, 8'd7);
        burst(8, 1'b0, 7, 1'b1, 32'hF020);

        // Simultaneous requests alternate starting with feature
        do_reset();
        I_feat_req = 1'b1; I_feat_addr = 32'h0; I_feat_beats = 16'd32;
        I_wgt_req = 1'b1;  I_wgt_addr = 32'h8000; I_wgt_beats = 16'd32; I_wgt_ch = 1'b1;
        tick();
        I_feat_req = 1'b0; I_wgt_req = 1'b0;
        expect_cmd(32'h0000, 8'd15);
        burst(16, 1'b0, 15, 1'b0, 32'hA000);
        expect_cmd(32'h8000, 8'd15);
        burst(16, 1'b1, 15, 1'b0, 32'hB000);
        expect_cmd(32'h0100, 8'd15);
        burst(16, 1'b0, 15, 1'b1, 32'hA010);
        expect_cmd(32'h8100, 8'd15);
        burst(16, 1'b1, 15, 1'b1, 32'hB010);
        chk("rr_err", 128'(O_err), 128'(0));

        // Command held stable while not ready
        feat_req(32'h2000, 16'd4);
        wait_cmd();
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", 128'(O_cmd_valid), 128'(1));
            chk("stall_addr", 128'(O_cmd_addr), 128'(32'h2000));
            chk("stall_len", 128'(O_cmd_len), 128'(3));
            chk("stall_no_beat", 128'(O_feature_dv), 128'(0));
            tick();
        end
        expect_cmd(32'h2000, 8'd3);
        burst(4, 1'b0, 3, 1'b1, 32'hC000);

        // Zero-beat weight request
        I_wgt_req = 1'b1; I_wgt_addr = 32'h4444; I_wgt_beats = 16'd0; I_wgt_ch = 1'b0;
        tick();
        I_wgt_req = 1'b0;
        chk("zero_done", 128'(O_wgt_done), 128'(1));
        chk("zero_busy", 128'(O_wgt_busy), 128'(0));
        chk("zero_cmd", 128'(O_cmd_valid), 128'(0));
        tick();
        chk("zero_done_pulse", 128'(O_wgt_done), 128'(0));
        chk("zero_cmd2", 128'(O_cmd_valid), 128'(0));
        chk("zero_busy2", 128'(O_wgt_busy), 128'(0));

        // Request while busy flags err[0]; ap_start clears it
        feat_req(32'h3000, 16'd16);
        feat_req(32'h9000, 16'd5);
        chk("busy_req_err", 128'(O_err), 128'(2'b01));
        ap_clear();
        expect_cmd(32'h3000, 8'd15);
        burst(16, 1'b0, 15, 1'b1, 32'hD000);

        // Early last: count still governs the burst end
        feat_req(32'h4000, 16'd16);
        expect_cmd(32'h4000, 8'd15);
        burst(16, 1'b0, 4, 1'b1, 32'hE000);
        chk("last_err", 128'(O_err), 128'(2'b10));
        ap_clear();

        // Stray beat outside DATA is dropped and flagged
        I_rd_dv = 1'b1;
        I_rd_data = 128'h5555;
        tick();
        I_rd_dv = 1'b0;
        chk("stray_dv", 128'(O_feature_dv), 128'(0));
        chk("stray_err", 128'(O_err), 128'(2'b10));
        ap_clear();

        // New request in the completing cycle is captured
        feat_req(32'h6000, 16'd1);
        expect_cmd(32'h6000, 8'd0);
        I_rd_dv = 1'b1; I_rd_last = 1'b1; I_rd_data = 128'h77;
        I_feat_req = 1'b1; I_feat_addr = 32'h7000; I_feat_beats = 16'd2;
        tick();
        I_rd_dv = 1'b0; I_rd_last = 1'b0; I_feat_req = 1'b0;
        chk("b2b_done", 128'(O_feat_done), 128'(1));
        chk("b2b_dv", 128'(O_feature_dv), 128'(1));
        chk("b2b_busy", 128'(O_feat_busy), 128'(1));
        chk("b2b_err", 128'(O_err), 128'(0));
        expect_cmd(32'h7000, 8'd1);
        burst(2, 1'b0, 1, 1'b1, 32'h1234);

        // Reset in the middle of a burst
        feat_req(32'h5000, 16'd16);
        expect_cmd(32'h5000, 8'd15);
        burst(3, 1'b0, -1, 1'b0, 32'h9900);
        I_rst = 1'b0;
        I_rd_dv = 1'b1;
        I_rd_data = 128'hABCD;
        tick();
        I_rd_dv = 1'b0;
        chk("mrst_feature", O_feature, 128'(0));
        chk("mrst_dv", 128'(O_feature_dv), 128'(0));
        chk("mrst_busy", 128'(O_feat_busy), 128'(0));
        chk("mrst_cmd", 128'(O_cmd_valid), 128'(0));
        chk("mrst_addr", 128'(O_cmd_addr), 128'(0));
        chk("mrst_err", 128'(O_err), 128'(0));
        I_rst = 1'b1;
        tick();
        chk("post_rst_cmd", 128'(O_cmd_valid), 128'(0));
        chk("post_rst_busy", 128'(O_feat_busy), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
